bus_expander_hs: RTL and testbench
==================================

Name: bus_expander_hs

Overview:
Parametrised successor to the single-port register expander. It maps one MCU address register, one data register and one status register onto up to NUM_REGS slave registers of DATA_W bits. Over the plain expander it adds a per-slave ready handshake with timeout, optional address auto-increment for block transfers, and sticky error flags. It sits between the MCU register bus and slow or variable-latency peripherals such as FIFOs, SPI bridges and flash controllers.

Parameters:
DATA_W, 16, width of data, address and status words.
ADDR_W, 6, slave address width; must be less than DATA_W.
NUM_REGS, 64, number of slave registers; at most 2**ADDR_W.
TIMEOUT, 255, wait cycles before abort; 0 disables the timeout.

Ports:
sysclk  in  1  system clock; all logic on its rising edge.
sysreset  in  1  reset; synchronous, active-high.
data_in  in  DATA_W  write data shared by the address and data registers.
data_load  in  1  MCU write strobe for the data register.
data_read  in  1  MCU read strobe for the data register.
data_out  out  DATA_W  last captured slave read data.
address_load  in  1  MCU write strobe for the address register.
address_out  out  ADDR_W  current slave address.
status_out  out  DATA_W  bit0 busy, bit1 timeout_err, bit2 overrun_err, bit3 inc_en; all other bits 0.
r  in  NUM_REGS*DATA_W  slave read data, flattened; slave i occupies bits [i*DATA_W +: DATA_W].
r_ready  in  NUM_REGS  slave i completes the access; tie high for zero-wait slaves.
r_read  out  NUM_REGS  one-hot, one-cycle read strobe.
r_load  out  NUM_REGS  one-hot, one-cycle write strobe.
r_load_data  out  DATA_W  captured write data.
critical_section  out  1  expander mid-sequence; the debugger must not break in.

Behaviour:
- Reset: all outputs 0; state IDLE; address 0; inc_en 0; all flags 0; timeout counter 0.
- States: IDLE, WR_WAIT, RD_WAIT.
- address_load in IDLE:
  - address <= data_in[ADDR_W-1:0]; inc_en <= data_in[DATA_W-1].
  - timeout_err and overrun_err clear.
  - critical_section <= 1.
- address_load while busy: ignored; overrun_err <= 1.
- Write: data_load at cycle T in IDLE.
  - r_load_data <= data_in; state <= WR_WAIT; busy=1 from T+1.
  - r_load[address]=1 at T+1 only.
- Read: data_read at cycle T in IDLE.
  - state <= RD_WAIT; busy=1 from T+1.
  - r_read[address]=1 at T+1 only.
- data_load and data_read both high in IDLE: the write proceeds; overrun_err <= 1.
- data_load or data_read while busy: ignored; overrun_err <= 1.
- Completion: first cycle C >= T+1 in a WAIT state with r_ready[address]=1.
  - RD_WAIT: data_out <= r[address] at C.
  - C+1: state IDLE, busy 0, critical_section 0.
  - If inc_en, address <= address+1, wrapping NUM_REGS-1 -> 0 (not 2**ADDR_W-1).
  - Minimum latency: 2 cycles from strobe to busy low.
- Timeout (TIMEOUT>0): counter clears on entering WAIT and increments each WAIT cycle without ready.
  - When it reaches TIMEOUT, abort: state IDLE, timeout_err <= 1, critical_section 0.
  - Address does not increment.
  - On read abort, data_out <= all ones.
  - Ready on the same cycle as the limit counts as completion, not timeout.
- Address decode: address >= NUM_REGS drives no strobe; r_ready is treated as 1 and r data as 0.
- data_out, r_load_data and address_out hold between transactions.
- sysreset mid-transaction aborts it: next cycle is IDLE with all strobes 0 and no flags set.

Test Plan:
- Write address 3, then data 16'hA5A5 with r_ready tied high -> r_load[3] high exactly 1 cycle at T+1; r_load_data=A5A5; busy low at T+2.
- Set r[5]=16'h1234; r_ready[5] held low 4 cycles, then high; issue read at address 5 -> data_out=1234 one cycle after ready; busy high exactly 5 cycles.
- Address load 16'h803E with NUM_REGS=64, then 3 writes -> strobes hit 62, 63, 0; status_out bit3=1.
- TIMEOUT=8, r_ready[7]=0, read at address 7 -> abort after 8 wait cycles; data_out=FFFF; status_out=16'h0002; address stays 7.
- data_read during a pending write, then an address_load -> overrun_err set, second access not strobed; next address_load clears the flags.
- Assert sysreset during WR_WAIT -> all outputs 0 the next cycle; a subsequent write completes normally.

Source files
------------

// File: rtl/bus_expander_hs.sv
// ---------------------------------------------------------------------------
// bus_expander_hs : MCU address/data/status registers fanned out to NUM_REGS
// slave registers with ready handshake, timeout, auto-increment. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_expander_hs #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 6,
   parameter int NUM_REGS = 64,
   parameter int TIMEOUT  = 255
) (
   input  logic                       sysclk,
   input  logic                       sysreset,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       data_load,
   input  logic                       data_read,
   output logic [DATA_W-1:0]          data_out,
   input  logic                       address_load,
   output logic [ADDR_W-1:0]          address_out,
   output logic [DATA_W-1:0]          status_out,
   input  logic [NUM_REGS*DATA_W-1:0] r,
   input  logic [NUM_REGS-1:0]        r_ready,
   output logic [NUM_REGS-1:0]        r_read,
   output logic [NUM_REGS-1:0]        r_load,
   output logic [DATA_W-1:0]          r_load_data,
   output logic                       critical_section
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   address;
   logic                inc_en;
   logic                timeout_err;
   logic                overrun_err;
   logic [CNT_W-1:0]    tcount;
   logic                timeout_hit;
   logic                busy;

   logic [NUM_REGS-1:0] onehot;
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_data;
   logic [ADDR_W-1:0]   address_inc;

   logic                start_wr;
   logic                start_rd;
   logic                complete;
   logic                abort;
   logic                overrun_set;

   // Out-of-range addresses match no slave: no strobe, ready forced, data 0.
   always_comb begin
      onehot    = '0;
      sel_ready = 1'b1;
      sel_data  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (address == ADDR_W'(i)) begin
            onehot[i] = 1'b1;
            sel_ready = r_ready[i];
            sel_data  = r[i*DATA_W +: DATA_W];
         end
      end
   end

   assign address_inc = (address == ADDR_W'(NUM_REGS - 1)) ? '0 : address + ADDR_W'(1);

   generate
      if (TIMEOUT > 0) begin : g_timeout
         // Abort on the cycle the count would reach TIMEOUT.
         assign timeout_hit = (tcount == CNT_W'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   assign busy = (state != IDLE);

   always_ff @(posedge sysclk) begin
      if (sysreset) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_wr    = 1'b0;
      start_rd    = 1'b0;
      complete    = 1'b0;
      abort       = 1'b0;
      overrun_set = 1'b0;
      case (state)
         IDLE: begin
            if (data_load) begin
               start_wr  = 1'b1;
               state_nxt = WR_WAIT;
               if (data_read) overrun_set = 1'b1;
            end else if (data_read) begin
               start_rd  = 1'b1;
               state_nxt = RD_WAIT;
            end
         end
         WR_WAIT, RD_WAIT: begin
            if (sel_ready) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
            if (data_load || data_read || address_load) overrun_set = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         address          <= '0;
         inc_en           <= 1'b0;
         timeout_err      <= 1'b0;
         overrun_err      <= 1'b0;
         tcount           <= '0;
         data_out         <= '0;
         r_load_data      <= '0;
         r_load           <= '0;
         r_read           <= '0;
         critical_section <= 1'b0;
      end else begin
         r_load <= '0;
         r_read <= '0;

         if (state == IDLE) tcount <= '0;
         else if (!sel_ready) tcount <= tcount + CNT_W'(1);

         if (state == IDLE && address_load) begin
            address          <= data_in[ADDR_W-1:0];
            inc_en           <= data_in[DATA_W-1];
            timeout_err      <= 1'b0;
            overrun_err      <= 1'b0;
            critical_section <= 1'b1;
         end

         if (start_wr) begin
            r_load_data      <= data_in;
            r_load           <= onehot;
            critical_section <= 1'b1;
         end

         if (start_rd) begin
            r_read           <= onehot;
            critical_section <= 1'b1;
         end

         if (complete) begin
            if (state == RD_WAIT) data_out <= sel_data;
            if (inc_en) address <= address_inc;
            critical_section <= 1'b0;
         end

         if (abort) begin
            if (state == RD_WAIT) data_out <= '1;
            timeout_err      <= 1'b1;
            critical_section <= 1'b0;
         end

         if (overrun_set) overrun_err <= 1'b1;
      end
   end

   assign address_out = address;
   assign status_out  = {{(DATA_W-4){1'b0}}, inc_en, overrun_err, timeout_err, busy};

endmodule

`default_nettype wire

// File: tb/tb_bus_expander_hs.sv
// ---------------------------------------------------------------------------
// tb_bus_expander_hs : scoreboard bench for bus_expander_hs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_expander_hs;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 6;
   localparam int NUM_REGS = 64;
   localparam int TIMEOUT  = 8;

   logic                       sysclk = 1'b0;
   logic                       sysreset;
   logic [DATA_W-1:0]          data_in;
   logic                       data_load;
   logic                       data_read;
   logic [DATA_W-1:0]          data_out;
   logic                       address_load;
   logic [ADDR_W-1:0]          address_out;
   logic [DATA_W-1:0]          status_out;
   logic [NUM_REGS*DATA_W-1:0] r;
   logic [NUM_REGS-1:0]        r_ready;
   logic [NUM_REGS-1:0]        r_read;
   logic [NUM_REGS-1:0]        r_load;
   logic [DATA_W-1:0]          r_load_data;
   logic                       critical_section;

   typedef struct {
      bit          is_write;
      int          idx;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   model_addr;
   bit   model_inc;

   bus_expander_hs #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .TIMEOUT(TIMEOUT)
   ) dut (
      .sysclk(sysclk), .sysreset(sysreset),
      .data_in(data_in), .data_load(data_load), .data_read(data_read),
      .data_out(data_out), .address_load(address_load), .address_out(address_out),
      .status_out(status_out), .r(r), .r_ready(r_ready),
      .r_read(r_read), .r_load(r_load), .r_load_data(r_load_data),
      .critical_section(critical_section)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic load_addr(input logic [15:0] v);
      data_in      = v;
      address_load = 1'b1;
      tick();
      address_load = 1'b0;
      model_addr   = int'(v[ADDR_W-1:0]);
      model_inc    = v[DATA_W-1];
   endtask

   function automatic logic [NUM_REGS-1:0] vec_of(input int idx);
      logic [NUM_REGS-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      sysreset = 1'b1;
      tick();
      tick();
      sysreset = 1'b0;
      tests++; if (status_out !== 16'h0000) begin fails++; $display("FAIL reset_status got=%h exp=0000", status_out); end
      tests++; if (data_out !== 16'h0000) begin fails++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
      tests++; if (address_out !== 6'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", address_out); end
      tests++; if ((r_load | r_read) !== '0) begin fails++; $display("FAIL reset_strobes got=%h/%h exp=0", r_load, r_read); end
      tests++; if (critical_section !== 1'b0) begin fails++; $display("FAIL reset_cs got=%b exp=0", critical_section); end
   endtask

   task automatic test_write_basic();
      exp_t e;
      r_ready = '1;
      load_addr(16'h0003);
      tests++; if (critical_section !== 1'b1) begin fails++; $display("FAIL wr_cs_set got=%b exp=1", critical_section); end
      sb.push_back('{1'b1, model_addr, 16'hA5A5});
      data_in   = 16'hA5A5;
      data_load = 1'b1;
      tick();
      data_load = 1'b0;
      e = sb.pop_front();
      tests++; if (r_load !== vec_of(e.idx)) begin fails++; $display("FAIL wr_strobe got=%h exp=%h", r_load, vec_of(e.idx)); end
      tests++; if (r_load_data !== e.data) begin fails++; $display("FAIL wr_data got=%h exp=%h", r_load_data, e.data); end
      tests++; if (status_out[0] !== 1'b1) begin fails++; $display("FAIL wr_busy_t1 got=%b exp=1", status_out[0]); end
      tick();
      tests++; if (status_out[0] !== 1'b0) begin fails++; $display("FAIL wr_busy_t2 got=%b exp=0", status_out[0]); end
      tests++; if (r_load !== '0) begin fails++; $display("FAIL wr_strobe_once got=%h exp=0", r_load); end
      tests++; if (critical_section !== 1'b0) begin fails++; $display("FAIL wr_cs_clear got=%b exp=0", critical_section); end
   endtask

   task automatic test_read_wait();
      exp_t e;
      int   busy_cycles = 0;
      r[5*DATA_W +: DATA_W] = 16'h1234;
      r_ready[5] = 1'b0;
      load_addr(16'h0005);
      sb.push_back('{1'b0, model_addr, 16'h1234});
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
      e = sb.pop_front();
      tests++; if (r_read !== vec_of(e.idx)) begin fails++; $display("FAIL rd_strobe got=%h exp=%h", r_read, vec_of(e.idx)); end
      for (int c = 0; c < 4; c++) begin
         if (status_out[0]) busy_cycles++;
         tick();
      end
      r_ready[5] = 1'b1;
      if (status_out[0]) busy_cycles++;
      tick();
      tests++; if (busy_cycles != 5) begin fails++; $display("FAIL rd_busy_len got=%0d exp=5", busy_cycles); end
      tests++; if (status_out[0] !== 1'b0) begin fails++; $display("FAIL rd_busy_end got=%b exp=0", status_out[0]); end
      tests++; if (data_out !== e.data) begin fails++; $display("FAIL rd_data got=%h exp=%h", data_out, e.data); end
   endtask

   task automatic test_auto_inc();
      exp_t e;
      r_ready = '1;
      load_addr(16'h803E);
      tests++; if (status_out[3] !== 1'b1) begin fails++; $display("FAIL inc_flag got=%b exp=1", status_out[3]); end
      for (int k = 1; k <= 3; k++) begin
         sb.push_back('{1'b1, model_addr, 16'(k * 16'h1111)});
         data_in   = 16'(k * 16'h1111);
         data_load = 1'b1;
         tick();
         data_load = 1'b0;
         e = sb.pop_front();
         tests++; if (r_load !== vec_of(e.idx)) begin fails++; $display("FAIL inc_strobe%0d got=%h exp=%h", k, r_load, vec_of(e.idx)); end
         tick();
         model_addr = (model_addr == NUM_REGS - 1) ? 0 : model_addr + 1;
      end
      tests++; if (int'(address_out) != model_addr) begin fails++; $display("FAIL inc_final_addr got=%0d exp=%0d", address_out, model_addr); end
   endtask

   task automatic test_timeout();
      exp_t e;
      int   n = 0;
      r_ready[7] = 1'b0;
      load_addr(16'h0007);
      sb.push_back('{1'b0, model_addr, 16'hFFFF});
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
      e = sb.pop_front();
      tests++; if (r_read !== vec_of(e.idx)) begin fails++; $display("FAIL to_strobe got=%h exp=%h", r_read, vec_of(e.idx)); end
      while (status_out[0] && n < 20) begin
         n++;
         tick();
      end
      tests++; if (n != TIMEOUT) begin fails++; $display("FAIL to_wait_len got=%0d exp=%0d", n, TIMEOUT); end
      tests++; if (data_out !== e.data) begin fails++; $display("FAIL to_data got=%h exp=%h", data_out, e.data); end
      tests++; if (status_out !== 16'h0002) begin fails++; $display("FAIL to_status got=%h exp=0002", status_out); end
      tests++; if (int'(address_out) != model_addr) begin fails++; $display("FAIL to_addr got=%0d exp=%0d", address_out, model_addr); end
      r_ready[7] = 1'b1;
   endtask

   task automatic test_overrun();
      exp_t e;
      r_ready[10] = 1'b0;
      load_addr(16'h000A);
      tests++; if (status_out !== 16'h0000) begin fails++; $display("FAIL ov_clear_to got=%h exp=0000", status_out); end
      sb.push_back('{1'b1, model_addr, 16'hBEEF});
      data_in   = 16'hBEEF;
      data_load = 1'b1;
      tick();
      data_load = 1'b0;
      e = sb.pop_front();
      tests++; if (r_load !== vec_of(e.idx)) begin fails++; $display("FAIL ov_wr_strobe got=%h exp=%h", r_load, vec_of(e.idx)); end
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
      tests++; if ((r_read | r_load) !== '0) begin fails++; $display("FAIL ov_no_strobe got=%h/%h exp=0", r_read, r_load); end
      tests++; if (status_out[2] !== 1'b1) begin fails++; $display("FAIL ov_flag got=%b exp=1", status_out[2]); end
      data_in      = 16'h0015;
      address_load = 1'b1;
      tick();
      address_load = 1'b0;
      tests++; if (int'(address_out) != model_addr) begin fails++; $display("FAIL ov_addr_hold got=%0d exp=%0d", address_out, model_addr); end
      r_ready[10] = 1'b1;
      tick();
      tests++; if (status_out !== 16'h0004) begin fails++; $display("FAIL ov_status got=%h exp=0004", status_out); end
      load_addr(16'h0015);
      tests++; if (status_out !== 16'h0000) begin fails++; $display("FAIL ov_cleared got=%h exp=0000", status_out); end
      tests++; if (int'(address_out) != model_addr) begin fails++; $display("FAIL ov_new_addr got=%0d exp=%0d", address_out, model_addr); end
   endtask

   task automatic test_dual_strobe();
      exp_t e;
      r_ready = '1;
      load_addr(16'h0002);
      sb.push_back('{1'b1, model_addr, 16'h2222});
      data_in   = 16'h2222;
      data_load = 1'b1;
      data_read = 1'b1;
      tick();
      data_load = 1'b0;
      data_read = 1'b0;
      e = sb.pop_front();
      tests++; if (r_load !== vec_of(e.idx)) begin fails++; $display("FAIL dual_wr got=%h exp=%h", r_load, vec_of(e.idx)); end
      tests++; if (r_read !== '0) begin fails++; $display("FAIL dual_rd got=%h exp=0", r_read); end
      tick();
      tests++; if (status_out !== 16'h0004) begin fails++; $display("FAIL dual_status got=%h exp=0004", status_out); end
   endtask

   task automatic test_reset_midway();
      exp_t e;
      load_addr(16'h0015);
      r_ready[21] = 1'b0;
      sb.push_back('{1'b1, model_addr, 16'h5555});
      data_in   = 16'h5555;
      data_load = 1'b1;
      tick();
      data_load = 1'b0;
      e = sb.pop_front();
      tests++; if (r_load !== vec_of(e.idx)) begin fails++; $display("FAIL rst_wr_strobe got=%h exp=%h", r_load, vec_of(e.idx)); end
      tick();
      sysreset = 1'b1;
      tick();
      sysreset = 1'b0;
      model_addr = 0;
      model_inc  = 1'b0;
      tests++; if (status_out !== 16'h0000) begin fails++; $display("FAIL rst_mid_status got=%h exp=0000", status_out); end
      tests++; if (r_load_data !== 16'h0000) begin fails++; $display("FAIL rst_mid_ldata got=%h exp=0000", r_load_data); end
      tests++; if (address_out !== 6'd0 || critical_section !== 1'b0) begin fails++; $display("FAIL rst_mid_addr_cs got=%0d/%b exp=0/0", address_out, critical_section); end
      r_ready = '1;
      sb.push_back('{1'b1, model_addr, 16'h0F0F});
      data_in   = 16'h0F0F;
      data_load = 1'b1;
      tick();
      data_load = 1'b0;
      e = sb.pop_front();
      tests++; if (r_load !== vec_of(e.idx) || r_load_data !== e.data) begin fails++; $display("FAIL rst_after_wr got=%h/%h exp=%h/%h", r_load, r_load_data, vec_of(e.idx), e.data); end
      tick();
      tests++; if (status_out[0] !== 1'b0) begin fails++; $display("FAIL rst_after_busy got=%b exp=0", status_out[0]); end
   endtask

   initial begin
      sysreset     = 1'b1;
      data_in      = '0;
      data_load    = 1'b0;
      data_read    = 1'b0;
      address_load = 1'b0;
      r            = '0;
      r_ready      = '1;
      model_addr   = 0;
      model_inc    = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = 16'(16'hC000 + i);

      test_reset();
      test_write_basic();
      test_read_wait();
      test_auto_inc();
      test_timeout();
      test_overrun();
      test_dual_strobe();
      test_reset_midway();

      tests++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
